scale_weight_filter: RTL and testbench
======================================

# scale_weight_filter

Front-end conditioning stage of the scale. It sits directly upstream of the grams-to-kilograms converter and drives its 14-bit `weightInGrams` input. It accepts raw load-cell readings in grams, averages them over a power-of-two window, and subtracts a stored tare. It then clamps the result to the displayable range and flags overload and reading stability.

## Interface
Parameters:
- `AVG_LOG2`, 3: averaging window is 2^AVG_LOG2 accepted samples.
- `MAX_GRAMS`, 9999: upper clamp of the net weight.
- `STABLE_TOL`, 2: maximum absolute difference in grams between consecutive net results that counts as "unchanged".
- `STABLE_COUNT`, 4: number of consecutive unchanged results needed before `stable` is asserted.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `rawGrams`  in  16  unsigned raw reading in grams.
- `rawValid`  in  1  `rawGrams` is accepted on any edge where this is high.
- `tareRequest`  in  1  already-debounced one-cycle pulse requesting re-tare.
- `weightInGrams`  out  14  net weight, clamped to 0..MAX_GRAMS.
- `weightValid`  out  1  one-cycle pulse when `weightInGrams` updates.
- `overload`  out  1  last net result exceeded MAX_GRAMS.
- `stable`  out  1  reading stable, see Configuration.
- `tareBusy`  out  1  a tare window is being collected.

## Operation
- FSM states:
  - RUN: normal averaging.
  - TARE: collect one window into the tare register.
- Accumulator width is 16+AVG_LOG2 bits and never overflows. The window counter is AVG_LOG2 bits and wraps to 0 at the end of each window.
- Window average = accumulator >> AVG_LOG2. The result is truncated, not rounded.
- RUN, on completion of a window:
  - net = average − tare, computed as 17-bit signed.
  - net < 0 → `weightInGrams`=0, `overload`=0.
  - net > MAX_GRAMS → `weightInGrams`=MAX_GRAMS, `overload`=1.
  - otherwise → `weightInGrams`=net, `overload`=0.
  - `weightValid` pulses for one cycle.
- `tareRequest` in RUN:
  - The partial window is discarded: accumulator and counter cleared.
  - FSM enters TARE and `tareBusy`=1.
  - `weightInGrams` and `overload` hold their values.
- TARE, on completion of a window:
  - tare ← average.
  - Stability history is cleared.
  - FSM returns to RUN, `tareBusy`=0.
  - No `weightValid` pulse is produced.
- `tareRequest` in TARE is ignored.
- Boundary cases:
  - `tareRequest` on the same edge as the final sample of a RUN window: tare wins. The sample is discarded and no `weightValid` pulse is produced.
  - `rawValid` on the edge RUN→TARE is entered: the sample is discarded.
  - `resetN` low mid-window: the partial accumulation is lost. The first window after release is built only from post-reset samples.

## Timing
- Reset values:
  - `weightInGrams`=0, `weightValid`=0, `overload`=0, `stable`=0, `tareBusy`=0.
  - tare=0, state RUN, accumulator=0, counter=0.
- Latency: `weightInGrams`, `overload` and `weightValid` update on the edge following the edge that accepted the window's final sample (one cycle).
- `stable` updates on the same edge as `weightValid`.
- `tareBusy` rises on the edge after `tareRequest`. It falls on the edge after the final sample of the tare window.
- Samples may arrive back-to-back every cycle with no gaps required.

## Configuration
- `SCALE_STABILITY_EN` defined:
  - Each RUN result is compared with the previous RUN result. A result with |diff| ≤ STABLE_TOL increments a saturating counter; any other result resets the counter to 0.
  - `stable` = (counter == STABLE_COUNT).
  - The first result after reset or tare only loads the previous-value register and leaves the counter at 0.
- `SCALE_STABILITY_EN` undefined:
  - The comparator and counter are not built.
  - `stable` is held at 1 after reset release.

## Test plan
- After reset, 8 samples of 1500 → one cycle after the 8th: `weightInGrams`=1500, one `weightValid` pulse, `overload`=0.
- `tareRequest`, then 8 samples of 200 → `tareBusy` high for the window and no `weightValid`. Then 8 samples of 1700 → `weightInGrams`=1500.
- Overload and underflow:
  - tare=0, 8 samples of 12000 → `weightInGrams`=9999, `overload`=1.
  - tare=200, 8 samples of 100 → `weightInGrams`=0, `overload`=0.
- Truncation: 1500 and 1501 alternating for 8 samples (sum 12004) → `weightInGrams`=1500.
- Stability, with `SCALE_STABILITY_EN`:
  - 5 windows of 1500 → `stable` rises with the 5th `weightValid`.
  - Then a window of 1510 → `stable`=0 on that pulse.
- Reset mid-window: 5 samples of 4000, pull `resetN` low for 2 cycles (all outputs 0), then 8 samples of 800 → `weightInGrams`=800. A simultaneous `tareRequest` with a final sample yields no pulse.

Source files
------------

// File: rtl/scale_weight_filter_if.sv
// Bus bundle between the load-cell front end and the scale filter.
// master: the sample source (drives readings and tare requests)
// slave : scale_weight_filter (drives the conditioned weight and flags)
interface scale_weight_filter_if;
    logic [15:0] rawGrams;
    logic        rawValid;
    logic        tareRequest;
    logic [13:0] weightInGrams;
    logic        weightValid;
    logic        overload;
    logic        stable;
    logic        tareBusy;

    modport master (
        output rawGrams, rawValid, tareRequest,
        input  weightInGrams, weightValid, overload, stable, tareBusy
    );

    modport slave (
        input  rawGrams, rawValid, tareRequest,
        output weightInGrams, weightValid, overload, stable, tareBusy
    );
endinterface

// File: rtl/scale_weight_filter.sv
// scale_weight_filter: averages raw load-cell readings over 2^AVG_LOG2
// samples, subtracts a stored tare, clamps to 0..MAX_GRAMS and flags
// overload. Optional stability tracking is built when the macro
// SCALE_STABILITY_EN is defined; otherwise 'stable' is held at 1 after reset.
module scale_weight_filter #(
    parameter int unsigned AVG_LOG2     = 3,
    parameter int unsigned MAX_GRAMS    = 9999,
    parameter int unsigned STABLE_TOL   = 2,
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    scale_weight_filter_if.slave  bus
);

    localparam int unsigned ACC_W = 16 + AVG_LOG2;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TARE = 1'b1;

    // Elaboration-time sanity of the configuration
    if (AVG_LOG2 < 1 || STABLE_COUNT < 1 || STABLE_TOL > 9999 || MAX_GRAMS > 16383) begin : g_bad_cfg
        $error("scale_weight_filter: unsupported parameter combination");
    end

    logic [0:0]          r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [15:0]         r_tare;
    logic [15:0]         r_winAvg;
    logic                r_winDone;
    logic                r_tareBusy;
    logic [13:0]         r_weight;
    logic                r_overload;
    logic                r_weightValid;
    logic                r_stable;

    logic [ACC_W-1:0]    w_sum;
    logic                w_last;
    logic [15:0]         w_avg;
    logic [16:0]         w_net;
    logic [13:0]         w_weight;
    logic                w_overload;
    logic                w_tareDone;

    assign w_sum      = r_acc + ACC_W'(bus.rawGrams);
    assign w_last     = (r_cnt == '1);
    assign w_avg      = 16'(w_sum >> AVG_LOG2);
    assign w_net      = {1'b0, r_winAvg} - {1'b0, r_tare};
    assign w_tareDone = (r_state == ST_TARE) && bus.rawValid && w_last;

    // Clamp the signed net value into the displayable range
    always_comb begin
        w_weight   = '0;
        w_overload = 1'b0;
        if (w_net[16]) begin
            w_weight   = '0;
            w_overload = 1'b0;
        end else if (w_net[15:0] > 16'(MAX_GRAMS)) begin
            w_weight   = 14'(MAX_GRAMS);
            w_overload = 1'b1;
        end else begin
            w_weight   = w_net[13:0];
            w_overload = 1'b0;
        end
    end

    // Window accumulation, tare capture and RUN/TARE sequencing
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_RUN;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_tare     <= '0;
            r_winAvg   <= '0;
            r_winDone  <= 1'b0;
            r_tareBusy <= 1'b0;
        end else begin
            r_winDone <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.tareRequest) begin
                        // Tare wins over any sample on this edge, including a window's last one
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= ST_TARE;
                        r_tareBusy <= 1'b1;
                    end else if (bus.rawValid) begin
                        if (w_last) begin
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_winAvg  <= w_avg;
                            r_winDone <= 1'b1;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.rawValid) begin
                        if (w_last) begin
                            r_acc      <= '0;
                            r_cnt      <= '0;
                            r_tare     <= w_avg;
                            r_state    <= ST_RUN;
                            r_tareBusy <= 1'b0;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Publish the clamped result one cycle after the window's last sample
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_weight      <= '0;
            r_overload    <= 1'b0;
            r_weightValid <= 1'b0;
        end else begin
            r_weightValid <= r_winDone;
            if (r_winDone) begin
                r_weight   <= w_weight;
                r_overload <= w_overload;
            end
        end
    end

`ifdef SCALE_STABILITY_EN
    localparam int unsigned SC_W = $clog2(STABLE_COUNT + 1);

    logic [13:0]     r_prev;
    logic            r_havePrev;
    logic [SC_W-1:0] r_scnt;
    logic [13:0]     w_diff;
    logic            w_within;
    logic [SC_W-1:0] w_scntNext;

    assign w_diff     = (w_weight >= r_prev) ? (w_weight - r_prev) : (r_prev - w_weight);
    assign w_within   = (w_diff <= 14'(STABLE_TOL));
    assign w_scntNext = (r_scnt == SC_W'(STABLE_COUNT)) ? r_scnt : (r_scnt + 1'b1);

    // Track consecutive near-equal RUN results; a completed tare restarts history
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_prev     <= '0;
            r_havePrev <= 1'b0;
            r_scnt     <= '0;
            r_stable   <= 1'b0;
        end else if (w_tareDone) begin
            r_havePrev <= 1'b0;
            r_scnt     <= '0;
            r_stable   <= 1'b0;
        end else if (r_winDone) begin
            r_prev <= w_weight;
            if (!r_havePrev) begin
                r_havePrev <= 1'b1;
                r_scnt     <= '0;
                r_stable   <= 1'b0;
            end else if (w_within) begin
                r_scnt   <= w_scntNext;
                r_stable <= (w_scntNext == SC_W'(STABLE_COUNT));
            end else begin
                r_scnt   <= '0;
                r_stable <= 1'b0;
            end
        end
    end
`else
    // Without stability tracking the reading is always reported stable
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_stable <= 1'b0;
        end else begin
            r_stable <= 1'b1;
        end
    end
`endif

    assign bus.weightInGrams = r_weight;
    assign bus.weightValid   = r_weightValid;
    assign bus.overload      = r_overload;
    assign bus.stable        = r_stable;
    assign bus.tareBusy      = r_tareBusy;

endmodule

// File: tb/tb_scale_weight_filter.sv
// Directed self-checking bench for scale_weight_filter (default parameters).
module tb_scale_weight_filter;

    logic clk;
    logic resetN;
    int   errors;
    int   checks;

    scale_weight_filter_if bus ();

    scale_weight_filter #(
        .AVG_LOG2     (3),
        .MAX_GRAMS    (9999),
        .STABLE_TOL   (2),
        .STABLE_COUNT (4)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted sample; inputs change 1 time unit after the edge
    task automatic push(input logic [15:0] v);
        bus.rawGrams = v;
        bus.rawValid = 1'b1;
        @(posedge clk);
        #1;
        bus.rawValid = 1'b0;
    endtask

    task automatic pulse_tare();
        bus.tareRequest = 1'b1;
        @(posedge clk);
        #1;
        bus.tareRequest = 1'b0;
    endtask

    // Full window alternating a/b; returns valid seen one cycle after the last
    // sample, count of any further pulses in a bounded 4-cycle watch, and weight
    task automatic run_window(input logic [15:0] a, input logic [15:0] b,
                              output logic first_vld, output int extra,
                              output logic [13:0] w);
        for (int i = 0; i < 8; i++) push((i % 2 == 0) ? a : b);
        @(posedge clk);
        #1;
        first_vld = bus.weightValid;
        w         = bus.weightInGrams;
        extra     = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.weightValid) extra++;
        end
    endtask

    // Tare window of constant value, no result pulse expected
    task automatic do_tare(input logic [15:0] v);
        pulse_tare();
        for (int i = 0; i < 8; i++) push(v);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.rawGrams = '0;
        bus.rawValid = 1'b0;
        bus.tareRequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.weightInGrams, bus.weightValid, bus.overload, bus.stable, bus.tareBusy} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got w=%0d v=%b o=%b s=%b t=%b, want all 0",
                     bus.weightInGrams, bus.weightValid, bus.overload, bus.stable, bus.tareBusy);
        end
        resetN = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.tareBusy !== 1'b0 || bus.weightInGrams !== 14'd0) begin
            errors++;
            $display("FAIL post_reset: got w=%0d t=%b, want 0 0", bus.weightInGrams, bus.tareBusy);
        end
`ifndef SCALE_STABILITY_EN
        checks++;
        if (bus.stable !== 1'b1) begin
            errors++;
            $display("FAIL stable_default: got %b, want 1", bus.stable);
        end
`endif
    endtask

    task automatic test_basic();
        logic v; int x; logic [13:0] w;
        run_window(16'd1500, 16'd1500, v, x, w);
        checks++;
        if (v !== 1'b1 || x !== 0 || w !== 14'd1500 || bus.overload !== 1'b0) begin
            errors++;
            $display("FAIL basic_1500: got vld=%b extra=%0d w=%0d ov=%b, want 1 0 1500 0", v, x, w, bus.overload);
        end
    endtask

    task automatic test_tare();
        logic v; int x; logic [13:0] w; int pulses;
        pulse_tare();
        checks++;
        if (bus.tareBusy !== 1'b1) begin
            errors++;
            $display("FAIL tare_busy_rise: got %b, want 1", bus.tareBusy);
        end
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            push(16'd200);
            if (bus.weightValid) pulses++;
            if (!bus.tareBusy) pulses += 100;
        end
        checks++;
        if (pulses !== 0 || bus.weightInGrams !== 14'd1500) begin
            errors++;
            $display("FAIL tare_window: got code=%0d w=%0d, want 0 1500", pulses, bus.weightInGrams);
        end
        push(16'd200);
        checks++;
        if (bus.tareBusy !== 1'b0) begin
            errors++;
            $display("FAIL tare_busy_fall: got %b, want 0", bus.tareBusy);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.weightValid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL tare_no_valid: got %0d pulses, want 0", pulses);
        end
        run_window(16'd1700, 16'd1700, v, x, w);
        checks++;
        if (v !== 1'b1 || w !== 14'd1500) begin
            errors++;
            $display("FAIL tared_1700: got vld=%b w=%0d, want 1 1500", v, w);
        end
    endtask

    task automatic test_clamp();
        logic v; int x; logic [13:0] w;
        do_tare(16'd0);
        run_window(16'd12000, 16'd12000, v, x, w);
        checks++;
        if (v !== 1'b1 || w !== 14'd9999 || bus.overload !== 1'b1) begin
            errors++;
            $display("FAIL overload: got vld=%b w=%0d ov=%b, want 1 9999 1", v, w, bus.overload);
        end
        do_tare(16'd200);
        run_window(16'd100, 16'd100, v, x, w);
        checks++;
        if (v !== 1'b1 || w !== 14'd0 || bus.overload !== 1'b0) begin
            errors++;
            $display("FAIL underflow: got vld=%b w=%0d ov=%b, want 1 0 0", v, w, bus.overload);
        end
        run_window(16'd10199, 16'd10199, v, x, w);
        checks++;
        if (w !== 14'd9999 || bus.overload !== 1'b0) begin
            errors++;
            $display("FAIL exact_max: got w=%0d ov=%b, want 9999 0", w, bus.overload);
        end
    endtask

    task automatic test_truncation();
        logic v; int x; logic [13:0] w;
        do_tare(16'd0);
        run_window(16'd1500, 16'd1501, v, x, w);
        checks++;
        if (v !== 1'b1 || w !== 14'd1500) begin
            errors++;
            $display("FAIL truncation: got vld=%b w=%0d, want 1 1500", v, w);
        end
    endtask

    task automatic test_stability();
        logic v; int x; logic [13:0] w; logic s4;
        do_tare(16'd0);
        s4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_window(16'd1500, 16'd1500, v, x, w);
            if (k == 3) s4 = bus.stable;
        end
`ifdef SCALE_STABILITY_EN
        checks++;
        if (s4 !== 1'b0 || bus.stable !== 1'b1) begin
            errors++;
            $display("FAIL stable_rise: got after4=%b after5=%b, want 0 1", s4, bus.stable);
        end
        run_window(16'd1510, 16'd1510, v, x, w);
        checks++;
        if (bus.stable !== 1'b0 || w !== 14'd1510) begin
            errors++;
            $display("FAIL stable_drop: got s=%b w=%0d, want 0 1510", bus.stable, w);
        end
`else
        checks++;
        if (s4 !== 1'b1 || bus.stable !== 1'b1) begin
            errors++;
            $display("FAIL stable_held: got after4=%b after5=%b, want 1 1", s4, bus.stable);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic v; int x; logic [13:0] w; int pulses;
        do_tare(16'd300);
        for (int i = 0; i < 5; i++) push(16'd4000);
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.weightInGrams, bus.weightValid, bus.overload, bus.stable, bus.tareBusy} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got w=%0d v=%b o=%b s=%b t=%b, want all 0",
                     bus.weightInGrams, bus.weightValid, bus.overload, bus.stable, bus.tareBusy);
        end
        resetN = 1'b1;
        @(posedge clk);
        #1;
        run_window(16'd800, 16'd800, v, x, w);
        checks++;
        if (v !== 1'b1 || x !== 0 || w !== 14'd800) begin
            errors++;
            $display("FAIL post_reset_window: got vld=%b extra=%0d w=%0d, want 1 0 800", v, x, w);
        end
        // Final sample coincides with a tare request
        for (int i = 0; i < 7; i++) push(16'd800);
        bus.tareRequest = 1'b1;
        push(16'd800);
        bus.tareRequest = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.weightValid) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.tareBusy !== 1'b1) begin
            errors++;
            $display("FAIL tare_vs_last: got pulses=%0d busy=%b, want 0 1", pulses, bus.tareBusy);
        end
        // The colliding sample must not count toward the tare window
        for (int i = 0; i < 7; i++) push(16'd100);
        checks++;
        if (bus.tareBusy !== 1'b1) begin
            errors++;
            $display("FAIL tare_discard: got busy=%b after 7 samples, want 1", bus.tareBusy);
        end
        push(16'd100);
        run_window(16'd900, 16'd900, v, x, w);
        checks++;
        if (v !== 1'b1 || w !== 14'd800) begin
            errors++;
            $display("FAIL back_to_run: got vld=%b w=%0d, want 1 800", v, w);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_tare();
        test_clamp();
        test_truncation();
        test_stability();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
